// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame-FSM states, prefix codes and key event record
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, RECV, STOP} rx_state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push while full is only taken alongside a pop
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic we, re;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign re    = pop & ~empty;
  assign we    = push & (~full | re);
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    wp_d  = wp_q + AW'(we);
    rp_d  = rp_q + AW'(re);
    cnt_d = cnt_q + (AW+1)'(we) - (AW+1)'(re);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (we) mem_q[wp_q] <= wdata;
endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard front end turning line activity into buffered key events
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV    = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic                          KEY_VALID,
  input  logic                          KEY_READY,
  output logic [7:0]                    KEY_CODE,
  output logic                          KEY_EXT,
  output logic                          KEY_BREAK,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] flt_cnt_q, flt_cnt_d;
  logic filt_q, filt_d;
  logic tick, fall, flip;
  rx_state_t state_q, state_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [8:0] sh_q, sh_d;
  logic [TW-1:0] idle_q, idle_d;
  logic ok_q, ok_d, err_q, err_d;
  logic [7:0] byte_q, byte_d;
  logic ext_q, ext_d, brk_q, brk_d, ovf_q, ovf_d;
  logic push, pop, full, empty;
  key_event_t ev_in, ev_out;
  assign tick = div_q == DW'(SAMPLE_DIV - 1);
  assign flip = tick && clk_s2_q != filt_q && flt_cnt_q == 4'(FILTER_LEN - 1);
  assign fall = filt_q & ~filt_d;
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    flt_cnt_d = !tick ? flt_cnt_q : (clk_s2_q == filt_q || flip) ? 4'd0 : flt_cnt_q + 4'd1;
    filt_d    = flip ? ~filt_q : filt_q;
  end
  // Frame FSM: advances on filtered falling edges, or aborts after TIMEOUT_TICKS quiet ticks
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    idle_d  = state_q == IDLE ? '0 : idle_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    byte_d  = byte_q;
    if (fall) begin
      idle_d = '0;
      if (state_q == IDLE) begin
        state_d = dat_s2_q ? IDLE : RECV;
        bcnt_d  = 4'd1;
        err_d   = dat_s2_q;
      end else if (state_q == RECV) begin
        sh_d    = {dat_s2_q, sh_q[8:1]};
        bcnt_d  = bcnt_q + 4'd1;
        state_d = bcnt_q == 4'd9 ? STOP : RECV;
      end else begin
        state_d = IDLE;
        ok_d    = dat_s2_q & ^sh_q;
        err_d   = ~ok_d;
        byte_d  = sh_q[7:0];
      end
    end else if (tick && state_q != IDLE) begin
      if (idle_q == TW'(TIMEOUT_TICKS - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end
  assign push  = ok_q && byte_q != PS2_EXT && byte_q != PS2_BRK;
  assign pop   = KEY_VALID & KEY_READY;
  assign ev_in = {ext_q, brk_q, byte_q};
  always_comb begin
    ext_d = err_q ? 1'b0 : (ok_q && byte_q == PS2_EXT) ? 1'b1 : push ? 1'b0 : ext_q;
    brk_d = err_q ? 1'b0 : (ok_q && byte_q == PS2_BRK) ? 1'b1 : push ? 1'b0 : brk_q;
    ovf_d = ovf_q | (push & full & ~pop);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      div_q     <= '0;
      flt_cnt_q <= '0;
      filt_q    <= 1'b1;
      state_q   <= IDLE;
      bcnt_q    <= '0;
      sh_q      <= '0;
      idle_q    <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      clk_s1_q  <= PS2_CLK;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= PS2_DATA;
      dat_s2_q  <= dat_s1_q;
      div_q     <= div_d;
      flt_cnt_q <= flt_cnt_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      idle_q    <= idle_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      ovf_q     <= ovf_d;
    end
  end
  sync_fifo #(.WIDTH($bits(key_event_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .wdata (ev_in),
    .rdata (ev_out),
    .full  (full),
    .empty (empty),
    .count (FIFO_COUNT)
  );
  assign KEY_VALID = ~empty;
  assign KEY_CODE  = KEY_VALID ? ev_out.code : 8'h00;
  assign KEY_EXT   = KEY_VALID & ev_out.ext;
  assign KEY_BREAK = KEY_VALID & ev_out.brk;
  assign FRAME_ERR = err_q;
  assign OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx: directed PS/2 frames against hand-computed key events
module tb_ps2_key_event_rx;
  localparam int HALF = 300;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, key_ready = 1'b0;
  logic key_valid, key_ext, key_break, frame_err, overflow;
  logic [7:0] key_code;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, ferr_n = 0, ferr0;
  ps2_key_event_rx #(.SAMPLE_DIV(4), .FILTER_LEN(2), .TIMEOUT_TICKS(50), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KEY_VALID(key_valid), .KEY_READY(key_ready), .KEY_CODE(key_code),
    .KEY_EXT(key_ext), .KEY_BREAK(key_break), .FRAME_ERR(frame_err),
    .OVERFLOW(overflow), .FIFO_COUNT(fifo_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_err) ferr_n <= ferr_n + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic pflip, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, ~^b ^ pflip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #HALF ps2_clk = 1'b0;
      #HALF ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #(2 * HALF);
    @(negedge clk);
  endtask
  task automatic pop_one();
    @(negedge clk) key_ready = 1'b1;
    @(negedge clk) key_ready = 1'b0;
  endtask
  initial begin
    logic [7:0] seq [5];
    seq = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    ferr0 = ferr_n;
    send(8'h1C, 0, 1, 11);
    check("1c_valid", key_valid, 1);
    check("1c_code", key_code, 8'h1C);
    check("1c_ext_brk", {key_ext, key_break}, 0);
    check("1c_count", fifo_count, 1);
    check("1c_ferr", ferr_n - ferr0, 0);
    pop_one();
    check("pop_count", fifo_count, 0);
    check("pop_code", key_code, 0);
    send(8'hE0, 0, 1, 11);
    send(8'hF0, 0, 1, 11);
    check("prefix_count", fifo_count, 0);
    send(8'h75, 0, 1, 11);
    check("ext_count", fifo_count, 1);
    check("ext_code", key_code, 8'h75);
    check("ext_flags", {key_ext, key_break}, 2'b11);
    pop_one();
    ferr0 = ferr_n;
    send(8'h1C, 1, 1, 11);
    check("par_ferr", ferr_n - ferr0, 1);
    check("par_count", fifo_count, 0);
    ferr0 = ferr_n;
    send(8'h1C, 0, 0, 11);
    check("stop_ferr", ferr_n - ferr0, 1);
    check("stop_count", fifo_count, 0);
    send(8'h1C, 0, 1, 11);
    check("after_err_code", key_code, 8'h1C);
    check("after_err_flags", {key_ext, key_break}, 0);
    pop_one();
    ferr0 = ferr_n;
    send(8'h29, 0, 1, 5);
    check("to_early", ferr_n - ferr0, 0);
    #3000;
    check("to_ferr", ferr_n - ferr0, 1);
    send(8'h29, 0, 1, 11);
    check("to_next_code", key_code, 8'h29);
    check("to_next_count", fifo_count, 1);
    pop_one();
    for (int i = 0; i < 5; i++) send(seq[i], 0, 1, 11);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), key_code, seq[i]);
      pop_one();
    end
    check("drain_count", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    send(8'h1C, 0, 1, 11);
    ferr0 = ferr_n;
    @(negedge clk) ps2_clk = 1'b0;
    #20 ps2_clk = 1'b1;
    #400;
    @(negedge clk);
    check("glitch_ferr", ferr_n - ferr0, 0);
    check("glitch_count", fifo_count, 1);
    send(8'h33, 0, 1, 5);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_code", key_code, 0);
    rst = 1'b0;
    ferr0 = ferr_n;
    send(8'h45, 0, 1, 11);
    check("post_rst_code", key_code, 8'h45);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_ferr", ferr_n - ferr0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver: samples the PS2_CLK/PS2_DATA lines, deglitches them, frames 11-bit packets, checks start/stop/odd parity, folds E0/F0 prefixes into a single key event, and buffers events in a FIFO with a valid/ready handshake. It is the next-generation keyboard front end, sitting between the board PS/2 pins and the parking-assignment control logic.

## Interface
- SAMPLE_DIV, 250: CLK cycles per sample tick (≥2)
- FILTER_LEN, 4: consecutive equal samples needed to accept a PS2_CLK level (1..15)
- TIMEOUT_TICKS, 4000: ticks without a falling edge before a partial frame is aborted
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2)
- CLK  in  1  board clock
- RESET  in  1  synchronous, active-high reset
- PS2_CLK  in  1  keyboard clock (asynchronous)
- PS2_DATA  in  1  keyboard data (asynchronous)
- KEY_VALID  out  1  FIFO head valid
- KEY_READY  in  1  consumer accepts head when KEY_VALID & KEY_READY
- KEY_CODE  out  8  scan code of head event
- KEY_EXT  out  1  head event was E0-prefixed
- KEY_BREAK  out  1  head event was F0-prefixed (release)
- FRAME_ERR  out  1  one-CLK pulse per rejected frame
- OVERFLOW  out  1  sticky: an event was dropped on full FIFO; cleared only by RESET
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  entries held

## Operation
- Both PS/2 lines pass a 2-flop synchroniser at CLK. Tick counter 0..SAMPLE_DIV-1; tick asserted one CLK when counter wraps.
- Filter (per tick): filtered PS2_CLK changes only after FILTER_LEN consecutive samples of the new level. Falling edge of filtered clock samples synchronised PS2_DATA.
- Frame FSM, advancing only on falling edges or timeout:
  - IDLE: data=0 → RECV, bit count 1; data=1 → FRAME_ERR, stay IDLE.
  - RECV: shift bits 1..9 (data LSB first, then parity); after bit 9 → STOP.
  - STOP: data=1 and XOR(data,parity)=1 → byte accepted; else FRAME_ERR. Always → IDLE.
  - RECV/STOP: idle counter reaches TIMEOUT_TICKS → FRAME_ERR, → IDLE; counter clears on every falling edge and in IDLE.
- Decoder on accepted byte: E0 sets ext_pend; F0 sets brk_pend; any other byte pushes {ext_pend, brk_pend, byte} and clears both. FRAME_ERR clears both pending flags.
- FIFO: push when full without same-cycle pop → event dropped, OVERFLOW=1. Full with simultaneous pop → push accepted. Empty: push visible next cycle, never bypassed.
- Outputs show FIFO head; KEY_CODE/EXT/BREAK = 0 when empty.

## Timing
- Reset values: KEY_VALID 0, KEY_CODE 0, KEY_EXT 0, KEY_BREAK 0, FRAME_ERR 0, OVERFLOW 0, FIFO_COUNT 0; tick counter 0; synchronisers and filtered clock 1; FSM IDLE; pending flags 0.
- Filter delay: filtered edge registered FILTER_LEN ticks after the raw edge's first sample.
- Byte accepted on tick T (STOP edge) → decoder push at CLK T+1 → KEY_VALID, FIFO_COUNT updated at T+2.
- FRAME_ERR asserted at T+1, exactly one CLK.
- Pop: head advances the CLK after KEY_VALID & KEY_READY; one pop per CLK sustained.
- RESET mid-frame or mid-prefix: everything returns to reset values next CLK; FIFO contents discarded.

## Structure
- Package ps2_pkg: FSM state enum (IDLE, RECV, STOP), constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, event struct {ext, brk, code[7:0]}.
- Sub-module sync_fifo (WIDTH, DEPTH) for the event buffer; synchroniser, filter, FSM, decoder in the top.

## Test plan
(bench uses SAMPLE_DIV=4, FILTER_LEN=2, TIMEOUT_TICKS=50, FIFO_DEPTH=4)
- Frame 0x1C, parity 0, stop 1 → one event CODE=1C EXT=0 BREAK=0, FIFO_COUNT=1, FRAME_ERR never high.
- Sequence E0, F0, 75 → exactly one event CODE=75 EXT=1 BREAK=1; prefix bytes produce no entries.
- 0x1C with parity 1; separately stop bit 0 → FRAME_ERR one pulse each, FIFO_COUNT=0; following good 0x1C accepted.
- 5 bits then line idle → FRAME_ERR after 50 ticks, FSM IDLE; next full 0x29 frame → CODE=29.
- KEY_READY=0, send 5 makes 0x16,0x1E,0x26,0x25,0x2E → FIFO_COUNT=4, OVERFLOW=1, drained order 16,1E,26,25.
- 1-sample low glitch on PS2_CLK in IDLE → no state change; RESET asserted after bit 4 → outputs at reset values, next frame decoded correctly.
